// File: rtl/hex_keypad_scanner_if.sv
// Consumer-side bundle of the hex keypad scanner: entered number, key events and the ack handshake.
`timescale 1ns/1ps
interface hex_keypad_scanner_if;
  logic        ack;
  logic [11:0] number;
  logic [1:0]  digits;
  logic        full;
  logic [3:0]  key_code;
  logic        key_strobe;
  logic        overrun;

  modport master (
    input  ack,
    output number, digits, full, key_code, key_strobe, overrun
  );

  modport slave (
    output ack,
    input  number, digits, full, key_code, key_strobe, overrun
  );
endinterface

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column drive, debounced key detection and a 3-digit entry buffer.
`timescale 1ns/1ps
module hex_keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            row,
  output logic [3:0]            col,
  hex_keypad_scanner_if.master  kp
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_RELEASE
  } state_e;

  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic             acc_hit_q, acc_hit_d;
  logic [3:0]       acc_code_q, acc_code_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [11:0]      number_q, number_d;
  logic [1:0]       digits_q, digits_d;
  logic             full_q, full_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_strobe_q, key_strobe_d;
  logic             overrun_q, overrun_d;

  logic             sample_c;
  logic             scan_done_c;
  logic             col_hit_c;
  logic [1:0]       row_idx_c;
  logic             scan_hit_c;
  logic [3:0]       scan_code_c;
  logic             accept_c;

  // Lowest active row in the currently driven column
  always_comb begin
    col_hit_c = 1'b0;
    row_idx_c = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2_q[r]) begin
        col_hit_c = 1'b1;
        row_idx_c = 2'(r);
      end
    end
  end

  // Column divider, drive and per-scan first-hit accumulator
  always_comb begin
    sample_c    = (div_q == DIV_LAST);
    scan_done_c = sample_c && (col_idx_q == 2'd3);
    scan_hit_c  = acc_hit_q | col_hit_c;
    scan_code_c = acc_hit_q ? acc_code_q : {row_idx_c, col_idx_q};

    div_d      = sample_c ? '0 : div_q + DIV_W'(1);
    col_idx_d  = sample_c ? col_idx_q + 2'd1 : col_idx_q;
    col_d      = ~(4'b0001 << col_idx_d);
    acc_hit_d  = acc_hit_q;
    acc_code_d = acc_code_q;
    if (sample_c) begin
      if (col_idx_q == 2'd3) begin
        acc_hit_d  = 1'b0;
        acc_code_d = 4'd0;
      end else if (!acc_hit_q && col_hit_c) begin
        acc_hit_d  = 1'b1;
        acc_code_d = {row_idx_c, col_idx_q};
      end
    end
  end

  // Debounce FSM, evaluated once per completed scan
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scan_done_c && scan_hit_c) begin
          cand_d  = scan_code_c;
          cnt_d   = CNT_ONE;
          state_d = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (scan_done_c) begin
          if (scan_hit_c && (scan_code_c == cand_q)) begin
            if (cnt_q + CNT_ONE == CNT_DONE) begin
              accept_c = 1'b1;
              cnt_d    = '0;
              state_d  = S_RELEASE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_RELEASE: begin
        if (scan_done_c) begin
          if (scan_hit_c) begin
            cnt_d = '0;
          end else if (cnt_q + CNT_ONE == CNT_DONE) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Entry buffer; an ack coinciding with an accept while full clears before the new digit lands
  always_comb begin
    number_d     = number_q;
    digits_d     = digits_q;
    full_d       = full_q;
    key_code_d   = key_code_q;
    key_strobe_d = accept_c;
    overrun_d    = 1'b0;
    if (accept_c) begin
      key_code_d = cand_q;
      if (full_q && kp.ack) begin
        number_d = {8'h00, cand_q};
        digits_d = 2'd1;
        full_d   = 1'b0;
      end else if (full_q) begin
        overrun_d = 1'b1;
      end else begin
        number_d = {number_q[7:0], cand_q};
        digits_d = digits_q + 2'd1;
        full_d   = (digits_q == 2'd2);
      end
    end else if (full_q && kp.ack) begin
      number_d = 12'h000;
      digits_d = 2'd0;
      full_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q     <= 4'hF;
      row_s2_q     <= 4'hF;
      div_q        <= '0;
      col_idx_q    <= 2'd0;
      col_q        <= 4'b1110;
      acc_hit_q    <= 1'b0;
      acc_code_q   <= 4'd0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cand_q       <= 4'd0;
      number_q     <= 12'h000;
      digits_q     <= 2'd0;
      full_q       <= 1'b0;
      key_code_q   <= 4'd0;
      key_strobe_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      row_s1_q     <= row;
      row_s2_q     <= row_s1_q;
      div_q        <= div_d;
      col_idx_q    <= col_idx_d;
      col_q        <= col_d;
      acc_hit_q    <= acc_hit_d;
      acc_code_q   <= acc_code_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      number_q     <= number_d;
      digits_q     <= digits_d;
      full_q       <= full_d;
      key_code_q   <= key_code_d;
      key_strobe_q <= key_strobe_d;
      overrun_q    <= overrun_d;
    end
  end

  assign col           = col_q;
  assign kp.number     = number_q;
  assign kp.digits     = digits_q;
  assign kp.full       = full_q;
  assign kp.key_code   = key_code_q;
  assign kp.key_strobe = key_strobe_q;
  assign kp.overrun    = overrun_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed bench for hex_keypad_scanner with a behavioural 4x4 keypad model (SCAN_DIV=4, DEBOUNCE_SCANS=2).
`timescale 1ns/1ps
module tb_hex_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] key_mask = 16'h0000;

  int n_pass    = 0;
  int n_total   = 0;
  int n_strobe  = 0;
  int n_overrun = 0;
  int s0;
  int o0;

  hex_keypad_scanner_if kp ();

  hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .row   (row),
    .col   (col),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  // Pressed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (kp.key_strobe) n_strobe++;
    if (kp.overrun)    n_overrun++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Returns #1 after the edge on which the column wraps 3->0 (end of a full scan)
  task automatic next_scan();
    logic [3:0] prev;
    bit seen;
    seen = 1'b0;
    prev = col;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (col == 4'b1110 && prev == 4'b0111) seen = 1'b1;
      prev = col;
    end
    if (!seen) begin
      n_total++;
      $error("FAIL scan_timeout: observed no wrap expected wrap within 40 clocks");
    end
  endtask

  task automatic scans(input int n);
    for (int i = 0; i < n; i++) next_scan();
  endtask

  task automatic set_key(input int k);
    key_mask = 16'h0001 << k;
  endtask

  task automatic press(input int k);
    set_key(k);
    scans(3);
    key_mask = 16'h0000;
    scans(3);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    kp.ack = 1'b0;
    #12;
    check("rst_col",        32'(col),           32'h0000_000E);
    check("rst_number",     32'(kp.number),     32'h0);
    check("rst_digits",     32'(kp.digits),     32'h0);
    check("rst_full",       32'(kp.full),       32'h0);
    check("rst_key_code",   32'(kp.key_code),   32'h0);
    check("rst_key_strobe", 32'(kp.key_strobe), 32'h0);
    check("rst_overrun",    32'(kp.overrun),    32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Key 6: row 1 seen only while column 2 is driven
    s0 = n_strobe;
    set_key(6);
    next_scan();
    check("k6_no_strobe_scan1", 32'(kp.key_strobe), 32'h0);
    next_scan();
    check("k6_strobe_scan2", 32'(kp.key_strobe), 32'h1);
    check("k6_key_code",     32'(kp.key_code),   32'h6);
    next_scan();
    key_mask = 16'h0000;
    scans(3);
    check("k6_strobe_count", 32'(n_strobe - s0), 32'h1);
    check("k6_number",       32'(kp.number),     32'h006);
    check("k6_digits",       32'(kp.digits),     32'h1);
    check("k6_full",         32'(kp.full),       32'h0);

    // ack while not full is ignored
    kp.ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 kp.ack = 1'b0;
    check("ack_notfull_number", 32'(kp.number), 32'h006);
    check("ack_notfull_digits", 32'(kp.digits), 32'h1);

    // Three digits fill the buffer, a fourth overruns
    do_reset();
    press(3);
    check("fill_digits1", 32'(kp.digits), 32'h1);
    press(10);
    press(15);
    check("fill_number", 32'(kp.number), 32'h3AF);
    check("fill_digits", 32'(kp.digits), 32'h3);
    check("fill_full",   32'(kp.full),   32'h1);
    o0 = n_overrun;
    set_key(5);
    scans(2);
    check("ovr_pulse",    32'(kp.overrun),    32'h1);
    check("ovr_strobe",   32'(kp.key_strobe), 32'h1);
    check("ovr_key_code", 32'(kp.key_code),   32'h5);
    next_scan();
    key_mask = 16'h0000;
    scans(3);
    check("ovr_number", 32'(kp.number),         32'h3AF);
    check("ovr_digits", 32'(kp.digits),         32'h3);
    check("ovr_count",  32'(n_overrun - o0),    32'h1);

    // ack while full clears on the next edge
    kp.ack = 1'b1;
    @(posedge clk); #1 kp.ack = 1'b0;
    check("ack_number", 32'(kp.number), 32'h000);
    check("ack_digits", 32'(kp.digits), 32'h0);
    check("ack_full",   32'(kp.full),   32'h0);

    // Single-scan glitch and a code that alternates between scans are rejected
    s0 = n_strobe;
    set_key(4);
    next_scan();
    key_mask = 16'h0000;
    scans(3);
    set_key(1); next_scan();
    set_key(2); next_scan();
    set_key(1); next_scan();
    set_key(2); next_scan();
    key_mask = 16'h0000;
    scans(3);
    check("glitch_no_strobe", 32'(n_strobe - s0), 32'h0);
    check("glitch_digits",    32'(kp.digits),     32'h0);

    // Keys D, 9 and 6 together: column 1 is scanned first and row 2 beats row 3
    key_mask = 16'h2240;
    scans(2);
    check("prio_strobe",   32'(kp.key_strobe), 32'h1);
    check("prio_key_code", 32'(kp.key_code),   32'h9);
    next_scan();
    key_mask = 16'h0000;
    scans(3);

    // Long hold, then a one-scan bounce during release
    s0 = n_strobe;
    set_key(12);
    scans(20);
    key_mask = 16'h0000;
    next_scan();
    set_key(12);
    next_scan();
    key_mask = 16'h0000;
    scans(3);
    check("hold_strobe_count", 32'(n_strobe - s0), 32'h1);
    check("hold_number",       32'(kp.number),     32'h09C);
    check("hold_digits",       32'(kp.digits),     32'h2);

    // Full, then ack lands in the accept cycle of key 7
    press(1);
    check("full_before_ack", 32'(kp.full),   32'h1);
    check("number_9c1",      32'(kp.number), 32'h9C1);
    o0 = n_overrun;
    set_key(7);
    next_scan();
    for (int i = 0; i < 20 && col != 4'b0111; i++) begin
      @(posedge clk); #1;
    end
    check("col3_reached", 32'(col), 32'h7);
    repeat (3) @(posedge clk);
    #1 kp.ack = 1'b1;
    @(posedge clk); #1 kp.ack = 1'b0;
    check("ackacc_strobe",   32'(kp.key_strobe), 32'h1);
    check("ackacc_overrun",  32'(kp.overrun),    32'h0);
    check("ackacc_number",   32'(kp.number),     32'h007);
    check("ackacc_digits",   32'(kp.digits),     32'h1);
    check("ackacc_full",     32'(kp.full),       32'h0);
    next_scan();
    key_mask = 16'h0000;
    scans(3);
    check("ackacc_no_overrun", 32'(n_overrun - o0), 32'h0);

    // Reset mid-debounce with the key still held
    set_key(9);
    next_scan();
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("mrst_col",        32'(col),           32'h0000_000E);
    check("mrst_number",     32'(kp.number),     32'h0);
    check("mrst_digits",     32'(kp.digits),     32'h0);
    check("mrst_full",       32'(kp.full),       32'h0);
    check("mrst_key_code",   32'(kp.key_code),   32'h0);
    check("mrst_key_strobe", 32'(kp.key_strobe), 32'h0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    next_scan();
    check("mrst_no_strobe_scan1", 32'(kp.key_strobe), 32'h0);
    next_scan();
    check("mrst_strobe_scan2", 32'(kp.key_strobe), 32'h1);
    check("mrst_key_code9",    32'(kp.key_code),   32'h9);
    check("mrst_number9",      32'(kp.number),     32'h009);
    key_mask = 16'h0000;
    scans(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
